// File: rtl/mat_vec_res_reader_pkg.sv
// Shared constants and types for the result-memory reader.
// Holds the parameter-set size table, the GF lane count and the FSM encoding.
// No logic; imported by the top and the serializer.
package mat_vec_res_reader_pkg;

  // Result vector length in bytes for each parameter set (matches the multiplier rows).
  localparam int RES_SIZE_L1   = 104;
  localparam int RES_SIZE_L2   = 159;
  localparam int RES_SIZE_L3   = 202;
  localparam int RES_SIZE_TEST = 20;

  // Bytes per result-memory word (GF lanes).
  localparam int GF_LANES = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/mat_vec_res_reader_word_byte_serializer.sv
// Purpose: shifts one N_GF-byte word out MSB lane first as a valid/ready byte stream.
// Latency: a loaded word presents byte 0 the cycle after i_load.
// Backpressure: o_byte/o_last hold while o_valid & ~i_ready; valid drops only after a transfer.
// Ports: i_load/i_word/i_limit/i_final load a word with its byte limit and final-word flag;
//        o_byte/o_valid/i_ready/o_last form the stream; o_word_end marks transfer of the word's last byte.
module mat_vec_res_reader_word_byte_serializer
  import mat_vec_res_reader_pkg::*;
#(
  parameter int  N_GF      = GF_LANES,
  parameter int  PROC_SIZE = N_GF * 8,
  localparam int BW        = $clog2(N_GF + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_load,
  input  logic [PROC_SIZE-1:0] i_word,
  input  logic [BW-1:0]        i_limit,
  input  logic                 i_final,
  output logic [7:0]           o_byte,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_last,
  output logic                 o_word_end
);

  logic [PROC_SIZE-1:0] act_q, act_d;
  logic [BW-1:0]        idx_q, idx_d;
  logic [BW-1:0]        lim_q, lim_d;
  logic                 vld_q, vld_d;
  logic                 fin_q, fin_d;

  logic xfer;
  logic at_end;

  assign xfer   = vld_q & i_ready;
  assign at_end = (idx_q == (lim_q - BW'(1)));

  always_comb begin
    act_d = act_q;
    idx_d = idx_q;
    lim_d = lim_q;
    vld_d = vld_q;
    fin_d = fin_q;
    if (i_load) begin
      // A load may coincide with the final transfer of the previous word,
      // which is how consecutive words join without a bubble.
      act_d = i_word;
      idx_d = '0;
      lim_d = i_limit;
      fin_d = i_final;
      vld_d = 1'b1;
    end else if (xfer && at_end) begin
      // Lanes beyond the limit are never shifted out.
      vld_d = 1'b0;
      idx_d = '0;
    end else if (xfer) begin
      act_d = act_q << 8;
      idx_d = idx_q + BW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      act_q <= '0;
      idx_q <= '0;
      lim_q <= '0;
      vld_q <= 1'b0;
      fin_q <= 1'b0;
    end else begin
      act_q <= act_d;
      idx_q <= idx_d;
      lim_q <= lim_d;
      vld_q <= vld_d;
      fin_q <= fin_d;
    end
  end

  assign o_byte     = act_q[PROC_SIZE-1 -: 8];
  assign o_valid    = vld_q;
  assign o_last     = vld_q & fin_q & at_end;
  assign o_word_end = xfer & at_end;

endmodule

// File: rtl/mat_vec_res_reader.sv
// Purpose: drains the GF(256) multiplier result memory after o_done and streams it as bytes.
// Latency: i_start at cycle 0 -> read at cycle 1 -> first byte valid at cycle 3; one-word prefetch hides reads.
// Backpressure: i_ready stalls the stream; prefetch stops once the buffer is full (one read in flight max).
// Ports: i_start kicks off a drain; o_res_addr/o_res_en/i_res drive the result read port (1-cycle latency);
//        o_byte/o_valid/i_ready/o_last form the stream; o_busy spans the drain, o_done pulses at its end.
module mat_vec_res_reader
  import mat_vec_res_reader_pkg::*;
#(
  parameter string PARAMETER_SET = "L3",
  parameter int    N_GF          = GF_LANES,
  parameter int    PROC_SIZE     = N_GF * 8,
  localparam int RES_SIZE_BYTES = (PARAMETER_SET == "L1") ? RES_SIZE_L1 :
                                  (PARAMETER_SET == "L2") ? RES_SIZE_L2 :
                                  (PARAMETER_SET == "L3") ? RES_SIZE_L3 : RES_SIZE_TEST,
  localparam int DEPTH          = (RES_SIZE_BYTES + N_GF - 1) / N_GF,
  localparam int REM_BYTES      = RES_SIZE_BYTES % N_GF,
  localparam int AW             = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW             = $clog2(DEPTH + 1),
  localparam int BW             = $clog2(N_GF + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  output logic [AW-1:0]        o_res_addr,
  output logic                 o_res_en,
  input  logic [PROC_SIZE-1:0] i_res,
  output logic [7:0]           o_byte,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_last,
  output logic                 o_busy,
  output logic                 o_done
);

  state_e               state_q, state_d;
  logic                 res_en_q, res_en_d;
  logic [AW-1:0]        res_addr_q, res_addr_d;
  logic                 rd_vld_q, rd_vld_d;     // i_res carries read data this cycle
  logic [CW-1:0]        rd_cnt_q, rd_cnt_d;     // reads issued so far
  logic [CW-1:0]        ld_cnt_q, ld_cnt_d;     // words handed to the serializer so far
  logic [PROC_SIZE-1:0] buf_q, buf_d;
  logic                 buf_vld_q, buf_vld_d;

  logic                 ser_load;
  logic [PROC_SIZE-1:0] ser_word;
  logic [BW-1:0]        ser_limit;
  logic                 ser_final;
  logic                 ser_valid;
  logic                 ser_last;
  logic                 ser_word_end;

  logic need_word;
  logic have_word;
  logic rd_idle;

  // The serializer wants a word when empty or when its current word finishes this cycle.
  assign need_word = ~ser_valid | ser_word_end;
  assign have_word = buf_vld_q | rd_vld_q;
  assign rd_idle   = ~res_en_q & ~rd_vld_q;

  // Buffered word has priority; otherwise arriving read data bypasses straight in.
  assign ser_word  = buf_vld_q ? buf_q : i_res;
  assign ser_final = (ld_cnt_q == CW'(DEPTH - 1));
  assign ser_limit = (ser_final && (REM_BYTES != 0)) ? BW'(REM_BYTES) : BW'(N_GF);

  always_comb begin
    state_d    = state_q;
    res_en_d   = 1'b0;
    res_addr_d = res_addr_q;
    rd_vld_d   = res_en_q;
    rd_cnt_d   = rd_cnt_q;
    ld_cnt_d   = ld_cnt_q;
    buf_d      = buf_q;
    buf_vld_d  = buf_vld_q;
    ser_load   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d    = ST_FILL;
          res_en_d   = 1'b1;
          res_addr_d = '0;
          rd_cnt_d   = CW'(1);
          ld_cnt_d   = '0;
          buf_vld_d  = 1'b0;
        end
      end

      ST_FILL: begin
        if (rd_vld_q) begin
          ser_load = 1'b1;
          ld_cnt_d = ld_cnt_q + CW'(1);
          state_d  = ST_STREAM;
        end
      end

      ST_STREAM: begin
        ser_load = need_word & have_word;
        if (ser_load) begin
          ld_cnt_d = ld_cnt_q + CW'(1);
        end
        if (ser_load && buf_vld_q) begin
          buf_vld_d = 1'b0;
        end
        // Park arriving data unless it was consumed directly by the bypass.
        if (rd_vld_q && !(ser_load && !buf_vld_q)) begin
          buf_d     = i_res;
          buf_vld_d = 1'b1;
        end
        // Prefetch only into an empty buffer with nothing outstanding.
        if (!buf_vld_q && rd_idle && (rd_cnt_q < CW'(DEPTH))) begin
          res_en_d   = 1'b1;
          res_addr_d = rd_cnt_q[AW-1:0];
          rd_cnt_d   = rd_cnt_q + CW'(1);
        end
        if (ser_last && i_ready) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      res_en_q   <= 1'b0;
      res_addr_q <= '0;
      rd_vld_q   <= 1'b0;
      rd_cnt_q   <= '0;
      ld_cnt_q   <= '0;
      buf_q      <= '0;
      buf_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      res_en_q   <= res_en_d;
      res_addr_q <= res_addr_d;
      rd_vld_q   <= rd_vld_d;
      rd_cnt_q   <= rd_cnt_d;
      ld_cnt_q   <= ld_cnt_d;
      buf_q      <= buf_d;
      buf_vld_q  <= buf_vld_d;
    end
  end

  mat_vec_res_reader_word_byte_serializer #(
    .N_GF      (N_GF),
    .PROC_SIZE (PROC_SIZE)
  ) u_ser (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (ser_load),
    .i_word     (ser_word),
    .i_limit    (ser_limit),
    .i_final    (ser_final),
    .o_byte     (o_byte),
    .o_valid    (ser_valid),
    .i_ready    (i_ready),
    .o_last     (ser_last),
    .o_word_end (ser_word_end)
  );

  assign o_valid    = ser_valid;
  assign o_last     = ser_last;
  assign o_res_en   = res_en_q;
  assign o_res_addr = res_addr_q;
  assign o_busy     = (state_q == ST_FILL) || (state_q == ST_STREAM);
  assign o_done     = (state_q == ST_DONE);

endmodule

// File: doc/mat_vec_res_reader.md
Name: mat_vec_res_reader

Overview:
- Drains the result memory of the GF(256) matrix-vector multiplier after it signals completion.
- Drives the multiplier's result-read port (address plus read-enable, 1-cycle read latency) word by word.
- Serialises each N_GF-byte word MSB-lane-first into a byte stream with valid/ready backpressure, for hashing/commitment logic downstream.
- Prefetches the next word while the current one is shifting out, so the stream has no bubbles under continuous i_ready.

Parameters:
- PARAMETER_SET, "L3": selects RES_SIZE_BYTES; any other value means test size.
- RES_SIZE_BYTES, L1 104 / L2 159 / L3 202 / else 20: result vector length in bytes.
- N_GF, 8: bytes per memory word (GF lanes).
- PROC_SIZE, N_GF*8: memory word width in bits.
- DEPTH, (RES_SIZE_BYTES+N_GF-1)/N_GF: number of words to read.
- REM_BYTES, RES_SIZE_BYTES%N_GF: valid bytes in the final word; 0 means the final word is full.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_start  in  1  start pulse; normally tied to the multiplier's o_done.
- o_res_addr  out  `CLOG2(DEPTH)  result memory word address.
- o_res_en  out  1  result-port ownership/read strobe; high only on cycles where a read is issued.
- i_res  in  PROC_SIZE  read data; valid the cycle after o_res_en.
- o_byte  out  8  stream data.
- o_valid  out  1  stream valid.
- i_ready  in  1  stream ready.
- o_last  out  1  high together with the final byte.
- o_busy  out  1  high from the cycle after an accepted start until o_done.
- o_done  out  1  one-cycle pulse after the final byte is accepted.

Behaviour:
- Reset is asynchronous and active-low. All outputs, state, counters and buffers go to 0 immediately, mid-stream included. No byte is emitted after reset; the bench restarts with i_start.
- States:
  - IDLE: i_start -> FILL. o_res_en=1, o_res_addr=0 registered for the next cycle. The start is ignored in every other state.
  - FILL: wait one cycle for read data.
  - STREAM: the active word register is shifted out.
  - DONE: o_done=1 for one cycle, o_busy=0, then -> IDLE.
- Handshake:
  - A byte transfers on a cycle with o_valid & i_ready.
  - While o_valid=1 and i_ready=0, o_byte and o_last hold stable.
  - o_valid never drops without a transfer.
- Byte order: lane 0 = i_res[PROC_SIZE-1:PROC_SIZE-8] goes out first, then descending lanes.
- Latency:
  - i_start at cycle 0 -> o_res_en=1, addr 0 at cycle 1.
  - i_res is captured into the active register at the end of cycle 2.
  - o_valid=1 with byte 0 at cycle 3.
- Prefetch:
  - One prefetch buffer plus a valid flag.
  - In STREAM, when the buffer is empty and words remain unread, issue a read (o_res_en=1, next address); capture i_res the next cycle.
  - At most one read is in flight.
  - When the last byte of the active word transfers and the buffer is valid, the buffer moves to the active register in the same edge, giving zero bubble.
  - If the buffer is not yet valid, o_valid drops until the capture.
- Counters:
  - Byte index inside the word runs 0..N_GF-1, wrapping to 0 on a word switch.
  - Word index runs 0..DEPTH-1.
  - On the final word, the byte limit is REM_BYTES when REM_BYTES≠0. Remaining lanes are discarded and never emitted.
- Termination:
  - o_last=1 exactly when word index=DEPTH-1 and byte index=limit-1.
  - A transfer with o_last -> DONE. o_valid=0 in DONE.
- Read addresses never exceed DEPTH-1, and no read is issued after address DEPTH-1.
- DEPTH=1: no prefetch reads occur.
- o_res_en is low in IDLE and DONE. The multiplier's result port is therefore free except during active reads.

Decomposition:
- Shared package:
  - PARAMETER_SET -> RES_SIZE_BYTES table (same values as the multiplier's row size).
  - N_GF and PROC_SIZE.
  - State encodings IDLE=0, FILL=1, STREAM=2, DONE=3.
- One natural sub-module: word_byte_serializer, covering the active register, byte counter, limit, valid/ready and last.
- The top level keeps the FSM, read issue, prefetch buffer and word counter.

Test Plan:
- TEST set, 20 bytes, memory words W0..W2 with W0=0x0001020304050607, W1=0x08090A0B0C0D0E0F, W2=0x10111213AAAAAAAA; i_ready=1; pulse start. Required: bytes 0x00..0x13 on 20 consecutive cycles starting 3 cycles after start; o_last on 0x13; 0xAA never appears; o_done one cycle later.
- Same data, i_ready toggling 1,0,0,1,... Required: o_byte and o_valid held while stalled; identical 20-byte sequence; exactly one read per word; addresses 0,1,2 only.
- i_ready=0 for 30 cycles after first valid. Required: o_valid=1, o_byte=0x00 held throughout; prefetch of W1 completes; no further o_res_en.
- i_rst_n asserted low at byte 9, then released. Required: all outputs 0 immediately; restart yields the full 0x00..0x13 sequence.
- i_start pulsed again mid-stream and during DONE. Required: ignored; a single stream and a single o_done.
- L1 (104 bytes, REM=0, DEPTH=13), ramp data, i_ready=1. Required: 104 contiguous bytes with no bubble between words; o_last on byte 103.
